// File: rtl/wakeup_pkg.sv
// Shared definitions for the wakeup scheduler: FSM state encoding and
// default requester count / delay width.
package wakeup_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;
endpackage

// File: rtl/wakeup_timer.sv
// Loadable down-counter that stops at zero; clear has priority over load.
module wakeup_timer
  import wakeup_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          zero
);

  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/wakeup_scheduler.sv
// Round-robin grant of a single shared wakeup countdown among NREQ requesters;
// pulses the served requester's wake line when its delay has elapsed.
module wakeup_scheduler
  import wakeup_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_dly,
  input  logic               abort,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    wake,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // First requester found scanning upward from the slot after the last winner.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] win;
    logic [IW-1:0] ix;
    logic          found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      ix = IW'((int'(last) + k) % NREQ);
      if (!found && r[ix]) begin
        found = 1'b1;
        win   = ix;
      end
    end
    return win;
  endfunction

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] wake_q;
  logic            busy_q;
  logic [IW-1:0]   last_q;

  logic            grant_d;
  logic [IW-1:0]   win_d;
  logic [NREQ-1:0] gnt_d;
  logic [DW-1:0]   dly_d;
  logic            tmr_clr;
  logic            tmr_zero;

  always_comb begin
    grant_d = (state_q == ST_IDLE) && (req != '0);
    win_d   = rr_pick(req, last_q);
    gnt_d   = NREQ'(1) << win_d;
    dly_d   = req_dly[int'(win_d)*DW +: DW];
    tmr_clr = rst || ((state_q == ST_COUNT) && abort);
  end

  wakeup_timer #(.DW(DW)) u_timer (
    .clk      (clk),
    .clr      (tmr_clr),
    .load     (grant_d),
    .load_val (dly_d),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      wake_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          wake_q <= '0;
          if (grant_d) begin
            gnt_q   <= gnt_d;
            busy_q  <= 1'b1;
            last_q  <= win_d;
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Abort wins over expiry: a cancelled service never wakes.
          if (abort) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmr_zero) begin
            wake_q  <= gnt_q;
            state_q <= ST_WAKE;
          end
        end
        ST_WAKE: begin
          wake_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          wake_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign wake = wake_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_wakeup_scheduler.sv
// Scoreboard bench for wakeup_scheduler: a timing-level reference model
// predicts grants and wake pulses; a negedge monitor compares DUT outputs.
module tb_wakeup_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               abort = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_dly = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    wake;
  logic               busy;

  initial forever #5 clk = ~clk;

  wakeup_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_dly (req_dly),
    .abort   (abort),
    .gnt     (gnt),
    .wake    (wake),
    .busy    (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int idx;
    int w;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   glog[$];

  // Reference model: each service is a time window. Grant at edge g with
  // delay D wakes at edge g+D+1, releases at g+D+2, next grant from g+D+3.
  int              edge_n = 0;
  bit              m_act  = 1'b0;
  int              m_idx  = 0;
  int              m_w    = 0;
  int              m_x    = 0;
  int              m_free = 0;
  int              m_last = NREQ - 1;
  int              m_c;
  bit              m_fnd;
  logic [NREQ-1:0] exp_gnt  = '0;
  logic            exp_busy = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      if (m_act && edge_n <= m_w && sbq.size() > 0) void'(sbq.pop_back());
      m_act  = 1'b0;
      m_last = NREQ - 1;
      m_free = edge_n + 1;
    end else if (m_act) begin
      if (edge_n == m_x) begin
        m_act  = 1'b0;
        m_free = edge_n + 1;
      end else if (abort) begin
        if (edge_n <= m_w && sbq.size() > 0) void'(sbq.pop_back());
        m_act  = 1'b0;
        m_free = edge_n + 1;
      end
    end else if (edge_n >= m_free && req != '0) begin
      m_fnd = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        m_c = (m_last + k) % NREQ;
        if (!m_fnd && req[m_c]) begin
          m_fnd = 1'b1;
          m_idx = m_c;
        end
      end
      m_w    = edge_n + int'(req_dly[m_idx*DW +: DW]) + 1;
      m_x    = m_w + 1;
      m_act  = 1'b1;
      m_last = m_idx;
      sbq.push_back('{m_idx, m_w});
    end
    exp_gnt  = m_act ? (NREQ'(1) << m_idx) : '0;
    exp_busy = m_act;
  end

  logic [NREQ-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    n_cmp++;
    if (gnt !== exp_gnt) begin
      n_fail++;
      $display("FAIL gnt @edge %0d: got %b want %b", edge_n, gnt, exp_gnt);
    end
    n_cmp++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy @edge %0d: got %b want %b", edge_n, busy, exp_busy);
    end
    if (wake !== '0) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL wake_unexpected @edge %0d: got %b want 0000", edge_n, wake);
      end else begin
        mon_e = sbq.pop_front();
        if (wake !== (NREQ'(1) << mon_e.idx) || edge_n != mon_e.w) begin
          n_fail++;
          $display("FAIL wake @edge %0d: got %b want idx %0d at edge %0d",
                   edge_n, wake, mon_e.idx, mon_e.w);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].w < edge_n) begin
      n_cmp++;
      n_fail++;
      mon_e = sbq.pop_front();
      $display("FAIL wake_missing @edge %0d: got none want idx %0d at edge %0d",
               edge_n, mon_e.idx, mon_e.w);
    end
    if (gnt != '0 && prev_gnt == '0) begin
      for (int k = 0; k < NREQ; k++) if (gnt[k]) glog.push_back(k);
    end
    prev_gnt = gnt;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dly(input int i, input int v);
    req_dly[i*DW +: DW] = DW'(v);
  endtask

  task automatic check_order(input string name, input int pos, input int want);
    n_cmp++;
    if (glog.size() <= pos) begin
      n_fail++;
      $display("FAIL %s[%0d]: got no grant want %0d", name, pos, want);
    end else if (glog[pos] != want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d want %0d", name, pos, glog[pos], want);
    end
  endtask

  int fair_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // single request, delay 5
    set_dly(1, 5); req = 4'b0010; tick(1); req = '0; tick(10);

    // zero delay, then full-scale delay
    set_dly(0, 0); req = 4'b0001; tick(1); req = '0; tick(5);
    set_dly(0, 255); req = 4'b0001; tick(1); req = '0; tick(262);

    // fairness from reset
    rst = 1'b1; tick(1); rst = 1'b0;
    glog.delete();
    for (int i = 0; i < NREQ; i++) set_dly(i, 2);
    req = 4'b1111; tick(30); req = '0; tick(8);
    for (int i = 0; i < 5; i++) check_order("fair_order", i, fair_order[i]);

    // request drop and delay change during service
    set_dly(2, 6); req = 4'b0100; tick(1); req = '0; tick(3);
    set_dly(2, 1); tick(12);

    // abort three cycles into a delay of 10, requester 1 pending
    glog.delete();
    set_dly(0, 10); set_dly(1, 3);
    req = 4'b0011; tick(1); tick(3);
    abort = 1'b1; tick(1); abort = 1'b0;
    tick(20); req = '0; tick(30);
    check_order("abort_order", 0, 0);
    check_order("abort_order", 1, 1);

    // reset mid-count, then all request
    glog.delete();
    set_dly(3, 20); req = 4'b1000; tick(1); req = '0; tick(5);
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_dly(i, 1);
    req = 4'b1111; tick(10); req = '0; tick(10);
    check_order("rst_order", 0, 3);
    check_order("rst_order", 1, 0);

    // randomized traffic with occasional abort and reset
    repeat (600) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_dly(i, $urandom_range(0, 12));
      abort = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    rst = 1'b0; abort = 1'b0; req = '0;
    tick(40);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
